// File: rtl/ysyx_22040759_mem_arbiter.sv
// ysyx_22040759_mem_arbiter
// Shares one memory port between the IF stage (read-only fetch) and the MEM stage
// (load/store). Only one transaction is outstanding at a time. MEM normally wins
// when both request, but IF is forced through after STARVE_MAX consecutive MEM wins
// that left IF waiting. A branch flush discards the response of an owned IF fetch
// while letting the memory side finish the transaction normally.

module ysyx_22040759_mem_arbiter #(
    parameter int AW         = 64,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,

    // instruction fetch master
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,

    // load/store master
    input  logic            mem_req,
    input  logic            mem_wen,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_wstrb,
    output logic            mem_gnt,
    output logic            mem_rvalid,
    output logic [DW-1:0]   mem_rdata,

    // shared memory port
    output logic            s_req,
    output logic            s_wen,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_ready,
    input  logic            s_rvalid,
    input  logic [DW-1:0]   s_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    state_t        state;
    state_t        state_nxt;
    owner_t        owner;
    logic [CW-1:0] starve_cnt;
    logic          drop;

    // Arbitration helpers, only meaningful while IDLE.
    logic          any_req;
    logic          starve_hit;
    logic          pick_mem;
    logic          launch;
    logic          done;

    assign any_req    = if_req | mem_req;
    assign starve_hit = (starve_cnt == CW'(STARVE_MAX));
    assign launch     = (state == ST_IDLE) & any_req;
    assign done       = (state == ST_DATA) & s_rvalid;

    // Read data is shared; the rvalid pulses alone decide who consumes it.
    assign if_rdata   = s_rdata;
    assign mem_rdata  = s_rdata;

    // Owner choice: MEM beats IF unless IF has already lost STARVE_MAX times in a row.
    always_comb begin
        pick_mem = 1'b0;
        if (mem_req && !(if_req && starve_hit)) begin
            pick_mem = 1'b1;
        end
    end

    // State register for the IDLE -> ADDR -> DATA transaction sequence.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: advance on any request, on accept, and on the memory response.
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (any_req)  state_nxt = ST_ADDR;
            ST_ADDR: if (s_ready)  state_nxt = ST_DATA;
            ST_DATA: if (s_rvalid) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Owner is latched when a transaction launches and stays locked until it completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_IF;
        end else if (launch) begin
            owner <= pick_mem ? OWN_MEM : OWN_IF;
        end
    end

    // Starvation counter: counts MEM wins that left IF waiting, saturating at STARVE_MAX.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (launch) begin
            if (pick_mem && if_req) begin
                if (!starve_hit) begin
                    starve_cnt <= starve_cnt + CW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Drop flag: a flush during an owned IF fetch suppresses that fetch's response.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (state == ST_IDLE || done) begin
            drop <= 1'b0;
        end else if (if_flush && owner == OWN_IF) begin
            drop <= 1'b1;
        end
    end

    // Output decode: drive the memory port in ADDR and route gnt/rvalid pulses to the owner.
    always_comb begin
        s_req      = 1'b0;
        s_wen      = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        s_wstrb    = '0;
        if_gnt     = 1'b0;
        mem_gnt    = 1'b0;
        if_rvalid  = 1'b0;
        mem_rvalid = 1'b0;

        case (state)
            ST_ADDR: begin
                s_req = 1'b1;
                if (owner == OWN_MEM) begin
                    s_wen   = mem_wen;
                    s_addr  = mem_addr;
                    s_wdata = mem_wdata;
                    s_wstrb = mem_wstrb;
                    mem_gnt = s_ready;
                end else begin
                    // Fetches are always reads with no byte strobes.
                    s_addr  = if_addr;
                    if_gnt  = s_ready;
                end
            end
            ST_DATA: begin
                if (s_rvalid) begin
                    if (owner == OWN_MEM) begin
                        mem_rvalid = 1'b1;
                    end else begin
                        // A flush landing in the response cycle also discards it.
                        if_rvalid = ~drop & ~if_flush;
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Testbench for ysyx_22040759_mem_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model with a byte-wise
// memory model standing in for the memory.

module tb_ysyx_22040759_mem_arbiter;

    localparam int AW         = 64;
    localparam int DW         = 64;
    localparam int SW         = DW / 8;
    localparam int STARVE_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          mem_req;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          s_req;
    logic          s_wen;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_ready;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Control bits: s_req s_wen if_gnt mem_gnt if_rvalid mem_rvalid
    wire [5:0] ctl = {s_req, s_wen, if_gnt, mem_gnt, if_rvalid, mem_rvalid};

    typedef struct {
        bit          valid;
        bit          accepted;
        bit          is_mem;
        bit          drop;
        bit          wen;
        int          wait_cyc;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] rdata;
    } txn_t;

    logic [63:0] model_mem [logic [63:0]];

    ysyx_22040759_mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .s_req(s_req), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [63:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d,
                                        input logic [7:0] strb);
        logic [63:0] cur;
        cur = model_read(a);
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) cur[8*b +: 8] = d[8*b +: 8];
        end
        model_mem[a] = cur;
    endfunction

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    // Leaves the caller just after a negedge with reset released and inputs idle.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        if_req = 1'b1; mem_req = 1'b1; if_flush = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000);
        end
        n_checks++;
        if ((s_addr | s_wdata | {56'h0, s_wstrb}) !== 64'h0) begin
            n_fail++; $display("FAIL reset_payload: got %h/%h/%h expected 0", s_addr, s_wdata, s_wstrb);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL reset_idle: got %b expected %b", ctl, 6'b000000);
        end
    endtask

    task automatic test_if_only();
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        apply_reset();
        if_req = 1'b1; if_addr = 64'h8000_0000; s_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL if_only_c0: got %b expected %b", ctl, 6'b000000);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({ctl, s_addr, s_wstrb} !== {6'b101000, 64'h8000_0000, 8'h00}) begin
            n_fail++; $display("FAIL if_only_gnt: got %b %h %h expected 101000 80000000 00", ctl, s_addr, s_wstrb);
        end
        @(negedge clk);
        if_req = 1'b0; if_addr = '0; s_rvalid = 1'b1; s_rdata = rd;
        #1;
        n_checks++;
        if ({ctl, if_rdata} !== {6'b000010, rd}) begin
            n_fail++; $display("FAIL if_only_rvalid: got %b %h expected 000010 %h", ctl, if_rdata, rd);
        end
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL if_only_done: got %b expected %b", ctl, 6'b000000);
        end
        clear_inputs();
    endtask

    task automatic test_both_store();
        logic [63:0] wd, rd;
        wd = {$urandom, $urandom};
        rd = {$urandom, $urandom};
        apply_reset();
        if_req = 1'b1; if_addr = 64'h8000_0100;
        mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 64'h8000_2000; mem_wdata = wd; mem_wstrb = 8'hFF;
        s_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({ctl, s_addr, s_wdata, s_wstrb} !== {6'b110100, 64'h8000_2000, wd, 8'hFF}) begin
            n_fail++; $display("FAIL both_mem_first: got %b %h %h %h expected 110100 80002000 %h ff", ctl, s_addr, s_wdata, s_wstrb, wd);
        end
        @(negedge clk);
        mem_req = 1'b0; mem_wen = 1'b0; s_rvalid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000001) begin
            n_fail++; $display("FAIL both_store_ack: got %b expected %b", ctl, 6'b000001);
        end
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL both_idle_pass: got %b expected %b", ctl, 6'b000000);
        end
        @(negedge clk); #1;
        n_checks++;
        if ({ctl, s_addr, s_wdata, s_wstrb} !== {6'b101000, 64'h8000_0100, 64'h0, 8'h00}) begin
            n_fail++; $display("FAIL both_if_second: got %b %h %h %h expected 101000 80000100 0 00", ctl, s_addr, s_wdata, s_wstrb);
        end
        @(negedge clk);
        if_req = 1'b0; s_rvalid = 1'b1; s_rdata = rd;
        #1;
        n_checks++;
        if ({ctl, if_rdata} !== {6'b000010, rd}) begin
            n_fail++; $display("FAIL both_if_rvalid: got %b %h expected 000010 %h", ctl, if_rdata, rd);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_starvation();
        int  k;
        bit  resp_next;
        bit  exp_if;
        k = 0;
        resp_next = 1'b0;
        apply_reset();
        if_req = 1'b1; if_addr = 64'h8000_0040;
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_3000; s_ready = 1'b1;
        for (int c = 0; c < 60 && k < 10; c++) begin
            @(negedge clk);
            s_rvalid = resp_next;
            resp_next = 1'b0;
            #1;
            if (if_gnt || mem_gnt) begin
                exp_if = (k % (STARVE_MAX + 1)) == STARVE_MAX;
                n_checks++;
                if ({if_gnt, mem_gnt} !== (exp_if ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL starve_order[%0d]: got if=%b mem=%b expected if=%b", k, if_gnt, mem_gnt, exp_if);
                end
                k++;
                resp_next = 1'b1;
            end
        end
        n_checks++;
        if (k != 10) begin
            n_fail++; $display("FAIL starve_count: got %0d grants expected 10", k);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_ready_stall();
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        apply_reset();
        if_req = 1'b1; if_addr = 64'h8000_0400; s_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_5000;
            end
            #1;
            n_checks++;
            if ({ctl, s_addr} !== {6'b100000, 64'h8000_0400}) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %b %h expected 100000 80000400", c, ctl, s_addr);
            end
        end
        @(negedge clk);
        s_ready = 1'b1;
        #1;
        n_checks++;
        if ({ctl, s_addr} !== {6'b101000, 64'h8000_0400}) begin
            n_fail++; $display("FAIL stall_gnt: got %b %h expected 101000 80000400", ctl, s_addr);
        end
        @(negedge clk);
        if_req = 1'b0; s_rvalid = 1'b1; s_rdata = rd;
        #1;
        n_checks++;
        if ({ctl, if_rdata} !== {6'b000010, rd}) begin
            n_fail++; $display("FAIL stall_rvalid: got %b %h expected 000010 %h", ctl, if_rdata, rd);
        end
        @(negedge clk);
        s_rvalid = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({ctl, s_addr} !== {6'b100100, 64'h8000_5000}) begin
            n_fail++; $display("FAIL stall_mem_after: got %b %h expected 100100 80005000", ctl, s_addr);
        end
        @(negedge clk);
        mem_req = 1'b0; s_rvalid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000001) begin
            n_fail++; $display("FAIL stall_mem_rvalid: got %b expected %b", ctl, 6'b000001);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_flush();
        logic [63:0] rd;
        rd = {$urandom, $urandom};
        apply_reset();
        // Flush in DATA, response three cycles later.
        if_req = 1'b1; if_addr = 64'h8000_0800; s_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL flush_data: got %b expected %b", ctl, 6'b000000);
        end
        @(negedge clk);
        if_flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        s_rvalid = 1'b1; s_rdata = rd;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL flush_dropped: got %b expected %b", ctl, 6'b000000);
        end
        // Next fetch is served normally.
        @(negedge clk);
        s_rvalid = 1'b0; if_req = 1'b1; if_addr = 64'h8000_0900;
        @(negedge clk); #1;
        n_checks++;
        if ({ctl, s_addr} !== {6'b101000, 64'h8000_0900}) begin
            n_fail++; $display("FAIL flush_next_gnt: got %b %h expected 101000 80000900", ctl, s_addr);
        end
        @(negedge clk);
        if_req = 1'b0; s_rvalid = 1'b1;
        #1;
        n_checks++;
        if ({ctl, if_rdata} !== {6'b000010, rd}) begin
            n_fail++; $display("FAIL flush_next_rvalid: got %b %h expected 000010 %h", ctl, if_rdata, rd);
        end
        // Flush coinciding with the response.
        @(negedge clk);
        s_rvalid = 1'b0; if_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b0; if_flush = 1'b1; s_rvalid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000000) begin
            n_fail++; $display("FAIL flush_same_cycle: got %b expected %b", ctl, 6'b000000);
        end
        // Flush in IDLE is ignored.
        @(negedge clk);
        s_rvalid = 1'b0; if_req = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0;
        @(negedge clk);
        if_req = 1'b0; s_rvalid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000010) begin
            n_fail++; $display("FAIL flush_idle_ignored: got %b expected %b", ctl, 6'b000010);
        end
        // Flush while MEM owns the port is ignored.
        @(negedge clk);
        s_rvalid = 1'b0; mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_6000; if_flush = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_req = 1'b0; s_rvalid = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 6'b000001) begin
            n_fail++; $display("FAIL flush_mem_ignored: got %b expected %b", ctl, 6'b000001);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        int k;
        bit resp_next;
        k = 0;
        resp_next = 1'b0;
        apply_reset();
        if_req = 1'b1; if_addr = 64'h8000_0a00;
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_7000; s_ready = 1'b1;
        for (int c = 0; c < 40 && k < STARVE_MAX; c++) begin
            @(negedge clk);
            s_rvalid = resp_next;
            resp_next = 1'b0;
            #1;
            if (mem_gnt) begin
                k++;
                resp_next = 1'b1;
            end
        end
        n_checks++;
        if (k != STARVE_MAX) begin
            n_fail++; $display("FAIL rst_mid_setup: got %0d mem grants expected %0d", k, STARVE_MAX);
        end
        // Reset lands in the DATA cycle of the last MEM transaction.
        @(negedge clk);
        rst = 1'b1; s_rvalid = 1'b0; if_req = 1'b0; mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; s_rvalid = 1'b1; s_rdata = {$urandom, $urandom};
        #1;
        n_checks++;
        if ({ctl, s_addr} !== {6'b000000, 64'h0}) begin
            n_fail++; $display("FAIL rst_mid_stale: got %b %h expected 000000 0", ctl, s_addr);
        end
        @(negedge clk);
        s_rvalid = 1'b0; if_req = 1'b1; mem_req = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== 6'b100100) begin
            n_fail++; $display("FAIL rst_mid_starve_clr: got %b expected %b", ctl, 6'b100100);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_random();
        logic [5:0]  exp_ctl;
        logic [63:0] exp_addr, exp_wdata;
        logic [7:0]  exp_wstrb;
        bit          if_done, mem_done, both;
        int          starve;
        txn_t        t;
        if_done = 1'b0; mem_done = 1'b0; starve = 0;
        t.valid = 1'b0; t.accepted = 1'b0; t.drop = 1'b0; t.wait_cyc = 0;
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (if_done)  begin if_req = 1'b0;  if_done = 1'b0;  end
            if (mem_done) begin mem_req = 1'b0; mem_done = 1'b0; end
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = 64'h8000_0000 | (64'($urandom_range(0, 15)) << 3);
            end
            if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req   = 1'b1;
                mem_wen   = 1'($urandom_range(0, 1));
                mem_addr  = 64'h8000_0000 | (64'($urandom_range(0, 15)) << 3);
                mem_wdata = {$urandom, $urandom};
                mem_wstrb = 8'($urandom);
            end
            s_ready  = ($urandom_range(0, 3) != 0);
            if_flush = ($urandom_range(0, 7) == 0);
            s_rdata  = {$urandom, $urandom};
            s_rvalid = 1'b0;
            if (t.valid && t.accepted && t.wait_cyc == 0) begin
                s_rvalid = 1'b1;
                s_rdata  = t.rdata;
            end else if (!(t.valid && t.accepted) && $urandom_range(0, 5) == 0) begin
                s_rvalid = 1'b1;  // stray response while no read is outstanding
            end
            #1;

            exp_ctl = '0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
            if (t.valid && !t.accepted) begin
                exp_ctl[5] = 1'b1;
                exp_ctl[4] = t.is_mem & t.wen;
                exp_addr   = t.addr;
                if (t.is_mem) begin
                    exp_wdata  = t.wdata;
                    exp_wstrb  = t.wstrb;
                    exp_ctl[2] = s_ready;
                end else begin
                    exp_ctl[3] = s_ready;
                end
            end else if (t.valid && s_rvalid) begin
                if (t.is_mem) exp_ctl[0] = 1'b1;
                else          exp_ctl[1] = !(t.drop || if_flush);
            end
            n_checks++;
            if ({ctl, s_addr, s_wdata, s_wstrb} !== {exp_ctl, exp_addr, exp_wdata, exp_wstrb}) begin
                n_fail++;
                $display("FAIL rnd_port[%0d]: got %b %h %h %h expected %b %h %h %h", c,
                         ctl, s_addr, s_wdata, s_wstrb, exp_ctl, exp_addr, exp_wdata, exp_wstrb);
            end
            if (exp_ctl[1]) begin
                n_checks++;
                if (if_rdata !== t.rdata) begin
                    n_fail++; $display("FAIL rnd_if_rdata[%0d]: got %h expected %h", c, if_rdata, t.rdata);
                end
            end
            if (exp_ctl[0]) begin
                n_checks++;
                if (mem_rdata !== t.rdata) begin
                    n_fail++; $display("FAIL rnd_mem_rdata[%0d]: got %h expected %h", c, mem_rdata, t.rdata);
                end
            end

            // Advance the transaction-level model.
            if (!t.valid) begin
                if (if_req || mem_req) begin
                    both     = if_req && mem_req;
                    t.is_mem = both ? (starve < STARVE_MAX) : mem_req;
                    if (t.is_mem && if_req) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
                    else                    starve = 0;
                    t.valid = 1'b1; t.accepted = 1'b0; t.drop = 1'b0;
                    t.wen   = t.is_mem ? mem_wen : 1'b0;
                    t.addr  = t.is_mem ? mem_addr : if_addr;
                    t.wdata = mem_wdata;
                    t.wstrb = mem_wstrb;
                end
            end else if (!t.accepted) begin
                if (if_flush && !t.is_mem) t.drop = 1'b1;
                if (s_ready) begin
                    t.accepted = 1'b1;
                    t.wait_cyc = $urandom_range(0, 3);
                    if (t.is_mem) begin
                        mem_done = 1'b1;
                        if (t.wen) begin
                            model_write(t.addr, t.wdata, t.wstrb);
                            t.rdata = {$urandom, $urandom};
                        end else begin
                            t.rdata = model_read(t.addr);
                        end
                    end else begin
                        if_done = 1'b1;
                        t.rdata = model_read(t.addr);
                    end
                end
            end else begin
                if (if_flush && !t.is_mem) t.drop = 1'b1;
                if (s_rvalid) t.valid = 1'b0;
                else          t.wait_cyc--;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_if_only();
        test_both_store();
        test_starvation();
        test_ready_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
